ball_motion_engine: RTL and testbench

//  Parametrised ball position/velocity engine for the Pong datapath, sitting between the game FSM
//  and the collision detectors. Generalises screen/ball geometry, tick period and per-axis step size.

---
 rtl/ball_motion_engine.sv | 212 +++++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ball_motion_engine.sv
// Pong ball position/velocity engine: tick-paced step handshake with the collision
// detectors, wall bounce, clamping and sticky scoring. Optional macro: SPEED_RAMP_EN.
module ball_motion_engine #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned BALL_SIZE = 16,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned TICK_W    = 19,
    parameter int unsigned STEP_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         state,
    input  logic               serve,
    input  logic [TICK_W-1:0]  tick_div,
    input  logic [STEP_W-1:0]  step_x,
    input  logic [STEP_W-1:0]  step_y,
    input  logic               hit_left,
    input  logic               hit_right,
    input  logic               hit_top,
    input  logic               hit_bottom,
    input  logic               coll_valid,
    output logic               coll_ack,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [1:0]         ball_status,
    output logic               bounce
);

    localparam int unsigned X_MAX = SCREEN_W - BALL_SIZE;
    localparam int unsigned Y_MAX = SCREEN_H - BALL_SIZE;
    localparam logic [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] ORIG_X  = COORD_W'(X_MAX / 2);
    localparam logic [COORD_W-1:0] ORIG_Y  = COORD_W'(Y_MAX / 2);

    typedef enum logic [1:0] {
        GS_START = 2'b00,
        GS_SERVE = 2'b01,
        GS_PLAY  = 2'b10,
        GS_DONE  = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        BS_PLAYING = 2'b00,
        BS_P1WIN   = 2'b01,
        BS_P2WIN   = 2'b10
    } ball_status_e;

    game_state_e  game_state;
    assign game_state = game_state_e'(state);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    ball_status_e       status_q, status_d;
    logic [TICK_W-1:0]  cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               coll_ack_q, coll_ack_d;
    logic               bounce_q, bounce_d;

    logic [STEP_W-1:0]  step_x_base, step_x_eff, step_y_eff;
    assign step_x_base = (step_x == '0) ? STEP_W'(1) : step_x;
    assign step_y_eff  = (step_y == '0) ? STEP_W'(1) : step_y;

`ifdef SPEED_RAMP_EN
    logic [STEP_W-1:0]  eff_step_q, eff_step_d;
    assign step_x_eff = eff_step_q;
`else
    assign step_x_eff = step_x_base;
`endif

    // Candidate step results, computed every cycle and committed only on a step.
    logic               dir_x_n, dir_y_n, dir_y_w, move_x, move_y, tick, step;
    logic [COORD_W:0]   x_wide, y_wide, sx_wide, sy_wide, x_sum, y_sum;
    logic [COORD_W-1:0] x_next, y_next;

    always_comb begin
        move_x = !(hit_left && hit_right);
        move_y = !(hit_top && hit_bottom);

        dir_x_n = dir_x_q;
        if (hit_right && !hit_left) dir_x_n = 1'b1;
        if (hit_left && !hit_right) dir_x_n = 1'b0;
        dir_y_n = dir_y_q;
        if (hit_bottom && !hit_top) dir_y_n = 1'b1;
        if (hit_top && !hit_bottom) dir_y_n = 1'b0;

        x_wide  = {1'b0, x_q};
        y_wide  = {1'b0, y_q};
        sx_wide = (COORD_W+1)'(step_x_eff);
        sy_wide = (COORD_W+1)'(step_y_eff);
        x_sum   = x_wide + sx_wide;
        y_sum   = y_wide + sy_wide;

        x_next = x_q;
        if (move_x) begin
            if (dir_x_n) x_next = (sx_wide > x_wide) ? '0 : x_q - COORD_W'(step_x_eff);
            else         x_next = (x_sum >= (COORD_W+1)'(X_MAX)) ? X_MAX_C : x_sum[COORD_W-1:0];
        end
        y_next = y_q;
        if (move_y) begin
            if (dir_y_n) y_next = (sy_wide > y_wide) ? '0 : y_q - COORD_W'(step_y_eff);
            else         y_next = (y_sum >= (COORD_W+1)'(Y_MAX)) ? Y_MAX_C : y_sum[COORD_W-1:0];
        end

        dir_y_w = dir_y_n;
        if (y_next == '0)     dir_y_w = 1'b0;
        if (y_next == Y_MAX_C) dir_y_w = 1'b1;
    end

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        status_d   = status_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        coll_ack_d = 1'b0;
        bounce_d   = 1'b0;
        tick       = 1'b0;
        step       = 1'b0;
`ifdef SPEED_RAMP_EN
        eff_step_d = eff_step_q;
`endif
        case (game_state)
            GS_PLAY: begin
                if (status_q == BS_PLAYING) begin
                    tick      = (cnt_q == tick_div);
                    cnt_d     = tick ? '0 : cnt_q + TICK_W'(1);
                    step      = pending_q && coll_valid;
                    pending_d = tick || (pending_q && !step);
                    if (step) begin
                        coll_ack_d = 1'b1;
                        x_d        = x_next;
                        y_d        = y_next;
                        dir_x_d    = dir_x_n;
                        dir_y_d    = dir_y_w;
                        if (x_next == '0)          status_d = BS_P2WIN;
                        else if (x_next == X_MAX_C) status_d = BS_P1WIN;
                        // A scoring step freezes the ball, so it never reports a paddle bounce.
                        bounce_d = (dir_x_n != dir_x_q) && (x_next != '0) && (x_next != X_MAX_C);
`ifdef SPEED_RAMP_EN
                        if (bounce_d && (eff_step_q != '1)) eff_step_d = eff_step_q + STEP_W'(1);
`endif
                    end
                end
            end
            GS_SERVE: begin
                x_d       = ORIG_X;
                y_d       = ORIG_Y;
                status_d  = BS_PLAYING;
                cnt_d     = '0;
                pending_d = 1'b0;
                dir_x_d   = serve;
                dir_y_d   = !dir_y_q;
`ifdef SPEED_RAMP_EN
                eff_step_d = step_x_base;
`endif
            end
            default: begin
                x_d       = ORIG_X;
                y_d       = ORIG_Y;
                status_d  = BS_PLAYING;
                cnt_d     = '0;
                pending_d = 1'b0;
                dir_x_d   = 1'b0;
                dir_y_d   = 1'b0;
`ifdef SPEED_RAMP_EN
                eff_step_d = step_x_base;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q        <= ORIG_X;
            y_q        <= ORIG_Y;
            dir_x_q    <= 1'b0;
            dir_y_q    <= 1'b0;
            status_q   <= BS_PLAYING;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            coll_ack_q <= 1'b0;
            bounce_q   <= 1'b0;
`ifdef SPEED_RAMP_EN
            eff_step_q <= step_x_base;
`endif
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            status_q   <= status_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            coll_ack_q <= coll_ack_d;
            bounce_q   <= bounce_d;
`ifdef SPEED_RAMP_EN
            eff_step_q <= eff_step_d;
`endif
        end
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign ball_status = status_q;
    assign coll_ack    = coll_ack_q;
    assign bounce      = bounce_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed self-checking bench for ball_motion_engine (default geometry 640x480, ball 16).
module tb_ball_motion_engine;

    localparam int ORX = (640 - 16) / 2;   // 312
    localparam int ORY = (480 - 16) / 2;   // 232

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  state;
    logic        serve;
    logic [18:0] tick_div;
    logic [2:0]  step_x, step_y;
    logic        hit_left, hit_right, hit_top, hit_bottom, coll_valid;
    logic        coll_ack, bounce;
    logic [9:0]  ball_x, ball_y;
    logic [1:0]  ball_status;

    int checks   = 0;
    int failures = 0;
    int es;

    ball_motion_engine #(
        .SCREEN_W(640), .SCREEN_H(480), .BALL_SIZE(16),
        .COORD_W(10), .TICK_W(19), .STEP_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .serve(serve), .tick_div(tick_div),
        .step_x(step_x), .step_y(step_y), .hit_left(hit_left), .hit_right(hit_right),
        .hit_top(hit_top), .hit_bottom(hit_bottom), .coll_valid(coll_valid),
        .coll_ack(coll_ack), .ball_x(ball_x), .ball_y(ball_y),
        .ball_status(ball_status), .bounce(bounce)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_step(input logic hl, input logic hr, input logic ht, input logic hb);
        @(negedge clk);
        hit_left = hl; hit_right = hr; hit_top = ht; hit_bottom = hb;
        coll_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            hit_left = 0; hit_right = 0; hit_top = 0; hit_bottom = 0;
            coll_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 0; state = 2'b00; serve = 0; tick_div = 19'd3;
        step_x = 3'd2; step_y = 3'd2;
        hit_left = 0; hit_right = 0; hit_top = 0; hit_bottom = 0; coll_valid = 0;

        // Reset
        @(posedge clk); #1;
        chk("rst_x", ball_x, ORX);
        chk("rst_y", ball_y, ORY);
        chk("rst_status", ball_status, 0);
        chk("rst_ack", coll_ack, 0);
        chk("rst_bounce", bounce, 0);

        // Serve toward -x for two cycles (dir_y returns to +y)
        @(negedge clk); rst_n = 1; state = 2'b01; serve = 1;
        repeat (2) @(posedge clk); #1;
        chk("serve_x", ball_x, ORX);
        chk("serve_status", ball_status, 0);

        // Handshake with tick_div=3 and coll_valid held
        @(negedge clk); state = 2'b10; coll_valid = 1;
        repeat (4) @(posedge clk); #1;
        chk("pre_tick_x", ball_x, ORX);
        chk("pre_tick_ack", coll_ack, 0);
        @(posedge clk); #1;
        chk("hs_x", ball_x, ORX - 2);
        chk("hs_y", ball_y, ORY + 2);
        chk("hs_ack", coll_ack, 1);
        @(negedge clk); coll_valid = 0;
        @(posedge clk); #1;
        chk("hs_ack_drop", coll_ack, 0);
        repeat (9) @(posedge clk); #1;
        chk("hold_x", ball_x, ORX - 2);
        chk("hold_y", ball_y, ORY + 2);
        @(negedge clk); coll_valid = 1;
        @(posedge clk); #1;
        chk("late_valid_x", ball_x, ORX - 4);
        chk("late_valid_ack", coll_ack, 1);

        // Paddle bounce, tick every cycle
        @(negedge clk); coll_valid = 0; state = 2'b01; serve = 1; tick_div = '0;
        repeat (2) @(posedge clk); #1;
        chk("reserve_x", ball_x, ORX);
        @(negedge clk); state = 2'b10;
        @(posedge clk); #1;
        do_step(1, 0, 0, 0);
        chk("bounce_x", ball_x, ORX + 2);
        chk("bounce_y", ball_y, ORY + 2);
        chk("bounce_pulse", bounce, 1);
        idle(1);
        chk("bounce_clear", bounce, 0);
        chk("ack_clear", coll_ack, 0);
`ifdef SPEED_RAMP_EN
        es = 3;
`else
        es = 2;
`endif
        do_step(0, 0, 0, 0);
        chk("post_bounce_x", ball_x, ORX + 2 + es);
        chk("post_bounce_y", ball_y, ORY + 4);
        chk("no_bounce", bounce, 0);

        // Both-sides x collision, bottom wall, then left scoring
        @(negedge clk); coll_valid = 0; state = 2'b01; serve = 1; step_x = 3'd7; step_y = 3'd7;
        repeat (2) @(posedge clk); #1;
        @(negedge clk); state = 2'b10;
        @(posedge clk); #1;
        do_step(1, 1, 0, 0);
        chk("both_x", ball_x, ORX);
        chk("both_y", ball_y, ORY + 7);
        chk("both_bounce", bounce, 0);
        repeat (32) do_step(1, 1, 0, 0);
        chk("near_wall_y", ball_y, 463);
        step_y = 3'd3;
        do_step(1, 1, 0, 0);
        chk("wall_clamp_y", ball_y, 464);
        do_step(1, 1, 0, 0);
        chk("wall_bounce_y", ball_y, 461);
        repeat (44) do_step(0, 0, 1, 1);
        chk("near_left_x", ball_x, 4);
        chk("near_left_status", ball_status, 0);
        do_step(0, 0, 1, 1);
        chk("left_clamp_x", ball_x, 0);
        chk("p2_score", ball_status, 2);
        do_step(0, 0, 0, 0);
        chk("frozen_x", ball_x, 0);
        chk("frozen_y", ball_y, 461);
        chk("frozen_ack", coll_ack, 0);
        chk("frozen_status", ball_status, 2);

        // Reset mid-PLAY with a step requested
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_x", ball_x, ORX);
        chk("midrst_y", ball_y, ORY);
        chk("midrst_status", ball_status, 0);
        chk("midrst_ack", coll_ack, 0);

        // Right-side scoring after serve toward +x
        @(negedge clk); rst_n = 1; coll_valid = 0; state = 2'b01; serve = 0;
        repeat (2) @(posedge clk); #1;
        @(negedge clk); state = 2'b10;
        @(posedge clk); #1;
        repeat (44) do_step(0, 0, 1, 1);
        chk("near_right_x", ball_x, 620);
        do_step(0, 0, 1, 1);
        chk("right_clamp_x", ball_x, 624);
        chk("p1_score", ball_status, 1);

        @(negedge clk); coll_valid = 0; state = 2'b11;
        @(posedge clk); #1;
        chk("done_x", ball_x, ORX);
        chk("done_status", ball_status, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
